// File: rtl/fifo_pkg.sv
// Shared constants, depth helper and op encoding for the single-clock FIFO and its RAM.
package fifo_pkg;

  localparam int unsigned LINE_SIZE_DEF    = 12;
  localparam int unsigned ADDRESS_SIZE_DEF = 3;

  // data_out reset value, replicated across the line width by users
  localparam bit DATA_OUT_RST_BIT = 1'b0;

  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic int unsigned fifo_depth(input int unsigned address_size);
    return 32'd1 << address_size;
  endfunction

endpackage

// File: rtl/fifo_sclk_param_if.sv
// Push/pop and status bundle for fifo_sclk_param; slave is the FIFO, master the user.
interface fifo_sclk_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned LINE_SIZE    = LINE_SIZE_DEF,
  parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF
) ();

  logic                  push;
  logic                  pop;
  logic [LINE_SIZE-1:0]  data_in;
  logic [LINE_SIZE-1:0]  data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDRESS_SIZE:0] count;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output push, pop, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow_err, underflow_err
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow_err, underflow_err
  );

endinterface

// File: rtl/dpram_sclk_param.sv
// Single-clock dual-port RAM: one write port, one registered read port, read-before-write.
module dpram_sclk_param
  import fifo_pkg::*;
#(
  parameter int unsigned LINE_SIZE    = LINE_SIZE_DEF,
  parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [ADDRESS_SIZE-1:0] i_waddr,
  input  logic [LINE_SIZE-1:0]    i_wdata,
  input  logic                    i_re,
  input  logic [ADDRESS_SIZE-1:0] i_raddr,
  output logic [LINE_SIZE-1:0]    o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDRESS_SIZE);

  logic [LINE_SIZE-1:0] r_mem [DEPTH];
  logic [LINE_SIZE-1:0] r_rdata;

  // Memory is never cleared; only the read register has a reset value.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read of the pre-edge contents gives read-before-write on collision.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdata <= {LINE_SIZE{DATA_OUT_RST_BIT}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sclk_param.sv
// Parametrised single-clock FIFO with registered flags; sticky error flags exist only when
// FIFO_ERR_FLAGS_EN is defined, otherwise overflow_err/underflow_err are tied low.
module fifo_sclk_param
  import fifo_pkg::*;
#(
  parameter int unsigned LINE_SIZE       = LINE_SIZE_DEF,
  parameter int unsigned ADDRESS_SIZE    = ADDRESS_SIZE_DEF,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              reset,
  fifo_sclk_param_if.slave  bus
);

  localparam int unsigned DEPTH = fifo_depth(ADDRESS_SIZE);
  localparam logic [ADDRESS_SIZE:0] DEPTH_CNT = (ADDRESS_SIZE+1)'(DEPTH);

  logic [ADDRESS_SIZE-1:0] r_wr_ptr;
  logic [ADDRESS_SIZE-1:0] r_rd_ptr;
  logic [ADDRESS_SIZE:0]   r_count;
  logic [ADDRESS_SIZE:0]   w_count_d;
  logic                    r_full;
  logic                    r_empty;
  logic                    r_afull;
  logic                    r_aempty;
  logic                    w_push_acc;
  logic                    w_pop_acc;
  fifo_op_e                w_op;

  // A push into a full FIFO is legal only when a pop frees the slot on the same edge.
  assign w_push_acc = !reset && bus.push && (!r_full || bus.pop);
  assign w_pop_acc  = !reset && bus.pop && !r_empty;
  assign w_op       = fifo_op_e'({w_push_acc, w_pop_acc});

  always_comb begin
    w_count_d = r_count;
    case (w_op)
      OpPush:  w_count_d = r_count + (ADDRESS_SIZE+1)'(1);
      OpPop:   w_count_d = r_count - (ADDRESS_SIZE+1)'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= (ALMOST_FULL_TH == 0);
      r_aempty <= 1'b1;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDRESS_SIZE'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDRESS_SIZE'(1);
      end
      r_count  <= w_count_d;
      r_full   <= (w_count_d == DEPTH_CNT);
      r_empty  <= (w_count_d == '0);
      r_afull  <= (32'(w_count_d) >= ALMOST_FULL_TH);
      r_aempty <= (32'(w_count_d) <= ALMOST_EMPTY_TH);
    end
  end

  dpram_sclk_param #(
    .LINE_SIZE    (LINE_SIZE),
    .ADDRESS_SIZE (ADDRESS_SIZE)
  ) u_ram (
    .clk     (clk),
    .i_rst   (reset),
    .i_we    (w_push_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_re    (w_pop_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.data_out)
  );

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.count        = r_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow_err;
  logic r_underflow_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (bus.push && r_full && !bus.pop) begin
        r_overflow_err <= 1'b1;
      end
      if (bus.pop && r_empty) begin
        r_underflow_err <= 1'b1;
      end
    end
  end

  assign bus.overflow_err  = r_overflow_err;
  assign bus.underflow_err = r_underflow_err;
`else
  assign bus.overflow_err  = 1'b0;
  assign bus.underflow_err = 1'b0;
`endif

endmodule
